fanin_8to1_collector: RTL and testbench
=======================================

FANIN_8TO1_COLLECTOR -- requirements
Module: fanin_8to1_collector

Interface
REQ-001 Parameter: DROP_W, default 8, width of the saturating dropped-event counter (legal 1..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: a, b, c, d, e, f, g, h  input  1 each  event lines from the 1-to-8 fanout tree; lane index a=0 ... h=7; high during a cycle = one event for that lane.
REQ-005 Port: out_valid  output  1  an event record is presented.
REQ-006 Port: out_ready  input  1  downstream accepts the record when out_valid is also high.
REQ-007 Port: out_lane  output  3  lane index of the presented record.
REQ-008 Port: pend  output  8  pending-event bitmap, bit i = lane i waiting (not yet in the output stage).
REQ-009 Port: drop_cnt  output  DROP_W  count of lost events.
REQ-010 Port: busy  output  1  high when out_valid or any pend bit is high.

Function
REQ-011 The block SHALL hold one pending bit per lane (P[7:0]) and a one-entry output stage (out_valid, out_lane).
REQ-012 At each edge, lane i with input high SHALL set P[i]; an input held high for K cycles SHALL count as K events.
REQ-013 An event on lane i while P[i]=1 and P[i] is not being cleared that edge SHALL be dropped and SHALL increment drop_cnt by 1.
REQ-014 drop_cnt SHALL saturate at 2^DROP_W-1; multiple drops in one edge SHALL add their count, clipped at saturation.
REQ-015 The output stage is "free" at an edge when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-016 When free and P!=0, the edge SHALL load the round-robin winner k into the output stage: out_valid=1, out_lane=k, P[k] cleared.
REQ-017 When free and P=0, the edge SHALL set out_valid=0; out_lane holds its last value.
REQ-018 When not free, out_valid and out_lane SHALL hold unchanged (no change while stalled).
REQ-019 Round-robin: 3-bit pointer ptr; the winner is the first set bit of P searching ptr, ptr+1, ... mod 8; after a load of lane k, ptr = (k+1) mod 8; ptr holds otherwise.
REQ-020 Simultaneous event and load on the same lane k SHALL leave P[k]=1 with no drop.
REQ-021 An event on lane k while lane k occupies the output stage and P[k]=0 SHALL set P[k] without a drop.
REQ-022 The winner SHALL be chosen from P before this edge's new events; events arriving at edge N are eligible for loading from edge N+1.
REQ-023 Latency: an event high in the cycle before edge N, with output stage free and P otherwise empty, SHALL produce out_valid=1 after edge N+1.
REQ-024 Throughput: one record per cycle while out_ready=1 and P!=0.
REQ-025 pend SHALL equal P; busy SHALL be combinational from out_valid and P.

Reset
REQ-026 rst_n low SHALL immediately clear P, out_valid, drop_cnt and ptr to 0 and out_lane to 0, regardless of clk.
REQ-027 Events present while rst_n is low SHALL be ignored; a record presented when reset asserts SHALL be discarded.
REQ-028 The first edge with rst_n high SHALL behave as a normal edge.

Verification
REQ-029 Single event: b high for one cycle before edge 1, out_ready=1 -> pend=8'h02 after edge 1, out_valid=1 out_lane=1 after edge 2, out_valid=0 after edge 3, drop_cnt=0.
REQ-030 All lanes at once: a..h high for one cycle, out_ready=1, ptr=0 -> out_lane sequence 0,1,2,...,7 on 8 consecutive cycles, then out_valid=0, drop_cnt=0.
REQ-031 Fairness: ptr=3, P=8'h81 (lanes 0,7) -> lane 7 loaded first, then lane 0, ptr ends at 1.
REQ-032 Stall and drop: out_ready=0, e high for 4 cycles -> first event loaded, second sets pend bit 4, third and fourth dropped, drop_cnt=2, out_lane=4 stable throughout stall.
REQ-033 Saturation: DROP_W=2, out_ready=0, lane 0 held high 10 cycles -> drop_cnt reaches 3 and holds.
REQ-034 Reset mid-operation: rst_n pulsed low asynchronously between edges with out_valid=1, pend=8'hF0 -> out_valid, pend, drop_cnt go 0 immediately, no record emitted after release until new events arrive.

Source files
------------

// File: rtl/fanin_8to1_collector.sv
// fanin_8to1_collector: gathers single-cycle events from eight lanes into a round-robin arbitrated one-entry output stage
module fanin_8to1_collector #(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  input  logic              d,
  input  logic              e,
  input  logic              f,
  input  logic              g,
  input  logic              h,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [2:0]        out_lane,
  output logic [7:0]        pend,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);
  localparam logic [16:0] DROP_MAX = 17'((17'd1 << DROP_W) - 17'd1);
  logic [7:0]        w_ev;
  logic [7:0]        w_clr;
  logic [7:0]        w_drop;
  logic [7:0]        w_pend_nxt;
  logic [2:0]        w_win;
  logic [3:0]        w_ndrop;
  logic [16:0]       w_sum;
  logic [DROP_W-1:0] w_drop_nxt;
  logic              w_free;
  logic              w_load;
  logic [7:0]        r_pend;
  logic              r_valid;
  logic [2:0]        r_lane;
  logic [2:0]        r_ptr;
  logic [DROP_W-1:0] r_drop;
  assign w_ev   = {h, g, f, e, d, c, b, a};
  assign w_free = !r_valid || out_ready;
  assign w_load = w_free && |r_pend;
  // first pending lane at or after the pointer, wrapping; lower offsets overwrite higher ones
  always_comb begin
    w_win = r_ptr;
    for (int j = 7; j >= 0; j--)
      if (r_pend[r_ptr + 3'(j)]) w_win = r_ptr + 3'(j);
  end
  // a load frees its pending bit the same edge, so a coinciding event on that lane re-arms it without a drop
  assign w_clr      = w_load ? (8'd1 << w_win) : 8'd0;
  assign w_drop     = w_ev & r_pend & ~w_clr;
  assign w_pend_nxt = w_ev | (r_pend & ~w_clr);
  // number of lanes losing an event this edge
  always_comb begin
    w_ndrop = 4'd0;
    for (int i = 0; i < 8; i++) w_ndrop = w_ndrop + {3'd0, w_drop[i]};
  end
  // saturating accumulation, computed wide enough for any legal DROP_W
  assign w_sum      = 17'(r_drop) + 17'(w_ndrop);
  assign w_drop_nxt = DROP_W'(w_sum > DROP_MAX ? DROP_MAX : w_sum);
  // pending bitmap, output stage, round-robin pointer and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 8'd0;
      r_valid <= 1'b0;
      r_lane  <= 3'd0;
      r_ptr   <= 3'd0;
      r_drop  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_drop <= w_drop_nxt;
      if (w_free) r_valid <= |r_pend;
      if (w_load) begin
        r_lane <= w_win;
        r_ptr  <= w_win + 3'd1;
      end
    end
  end
  assign out_valid = r_valid;
  assign out_lane  = r_lane;
  assign pend      = r_pend;
  assign drop_cnt  = r_drop;
  assign busy      = r_valid || |r_pend;
endmodule

// File: tb/tb_fanin_8to1_collector.sv
// tb_fanin_8to1_collector: directed scenarios plus randomized traffic against a lane-array reference model
module tb_fanin_8to1_collector;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       a = 0, b = 0, c = 0, d = 0, e = 0, f = 0, g = 0, h = 0;
  logic       out_ready = 1'b1;
  logic       out_valid, busy;
  logic [2:0] out_lane;
  logic [7:0] pend;
  logic [7:0] drop_cnt;
  logic       o2_valid, o2_busy;
  logic [2:0] o2_lane;
  logic [7:0] o2_pend;
  logic [1:0] o2_drop;
  int checks = 0;
  int failures = 0;
  bit m_p[8];
  bit m_ov;
  int m_lane, m_ptr, m_drops;

  fanin_8to1_collector dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .out_ready(out_ready), .out_valid(out_valid), .out_lane(out_lane), .pend(pend),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  fanin_8to1_collector #(.DROP_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .out_ready(out_ready), .out_valid(o2_valid), .out_lane(o2_lane), .pend(o2_pend),
    .drop_cnt(o2_drop), .busy(o2_busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_p[i] = 0;
    m_ov = 0; m_lane = 0; m_ptr = 0; m_drops = 0;
  endtask

  // one rising edge of the specified behaviour: pick winner from old pending set, then apply events
  task automatic model_edge(input logic [7:0] ev, input logic rdy);
    bit free;
    int k;
    free = !m_ov || rdy;
    k = -1;
    if (free) begin
      for (int j = 0; j < 8; j++)
        if (k < 0 && m_p[(m_ptr + j) % 8]) k = (m_ptr + j) % 8;
      if (k >= 0) begin
        m_ov = 1; m_lane = k; m_ptr = (k + 1) % 8;
      end else m_ov = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (ev[i]) begin
        if (m_p[i] && i != k) m_drops++;
        m_p[i] = 1;
      end else if (i == k) m_p[i] = 0;
    end
  endtask

  function automatic logic [7:0] exp_pend();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_p[i];
    return v;
  endfunction

  function automatic int sat(input int v, input int mx);
    return v > mx ? mx : v;
  endfunction

  task automatic tick(input logic [7:0] ev, input logic rdy);
    @(negedge clk);
    {h, g, f, e, d, c, b, a} = ev;
    out_ready = rdy;
    @(posedge clk);
    model_edge(ev, rdy);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    {h, g, f, e, d, c, b, a} = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    model_clear();
    checks++; if (pend !== 8'h00) begin failures++; $display("FAIL reset_pend got=%h exp=00", pend); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_lane !== 3'd0) begin failures++; $display("FAIL reset_lane got=%0d exp=0", out_lane); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    tick(8'h02, 1'b1);
    checks++; if (pend !== 8'h02 || out_valid !== 1'b0) begin failures++; $display("FAIL single_edge1 pend=%h valid=%b exp pend=02 valid=0", pend, out_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick(8'h00, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_lane !== 3'd1 || pend !== 8'h00) begin failures++; $display("FAIL single_edge2 valid=%b lane=%0d pend=%h exp 1/1/00", out_valid, out_lane, pend); end
    tick(8'h00, 1'b1);
    checks++; if (out_valid !== 1'b0 || drop_cnt !== 8'd0 || out_lane !== 3'd1) begin failures++; $display("FAIL single_edge3 valid=%b drop=%0d lane=%0d exp 0/0/1", out_valid, drop_cnt, out_lane); end
  endtask

  task automatic test_all_lanes();
    do_reset();
    tick(8'hFF, 1'b1);
    checks++; if (pend !== 8'hFF) begin failures++; $display("FAIL all_pend got=%h exp=ff", pend); end
    for (int j = 0; j < 8; j++) begin
      tick(8'h00, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_lane !== 3'(j)) begin failures++; $display("FAIL all_seq%0d valid=%b lane=%0d exp 1/%0d", j, out_valid, out_lane, j); end
    end
    tick(8'h00, 1'b1);
    checks++; if (out_valid !== 1'b0 || drop_cnt !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL all_end valid=%b drop=%0d busy=%b exp 0/0/0", out_valid, drop_cnt, busy); end
  endtask

  task automatic test_fairness();
    do_reset();
    tick(8'h04, 1'b1);
    tick(8'h00, 1'b1);
    tick(8'h81, 1'b1);
    checks++; if (pend !== 8'h81 || out_valid !== 1'b0) begin failures++; $display("FAIL fair_setup pend=%h valid=%b exp 81/0", pend, out_valid); end
    tick(8'h00, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_lane !== 3'd7) begin failures++; $display("FAIL fair_first lane=%0d valid=%b exp 7/1", out_lane, out_valid); end
    tick(8'h00, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_lane !== 3'd0) begin failures++; $display("FAIL fair_second lane=%0d valid=%b exp 0/1", out_lane, out_valid); end
    checks++; if (dut.r_ptr !== 3'd1) begin failures++; $display("FAIL fair_ptr got=%0d exp=1", dut.r_ptr); end
  endtask

  task automatic test_stall_drop();
    do_reset();
    tick(8'h10, 1'b0);
    checks++; if (pend !== 8'h10 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_e1 pend=%h valid=%b exp 10/0", pend, out_valid); end
    for (int j = 0; j < 5; j++) begin
      tick(j < 3 ? 8'h10 : 8'h00, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_lane !== 3'd4 || pend !== 8'h10) begin failures++; $display("FAIL stall_hold%0d valid=%b lane=%0d pend=%h exp 1/4/10", j, out_valid, out_lane, pend); end
    end
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL stall_drop got=%0d exp=2", drop_cnt); end
    tick(8'h00, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_lane !== 3'd4 || pend !== 8'h00) begin failures++; $display("FAIL stall_release valid=%b lane=%0d pend=%h exp 1/4/00", out_valid, out_lane, pend); end
    tick(8'h00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int j = 0; j < 10; j++) begin
      tick(8'h01, 1'b0);
      checks++; if (o2_drop !== 2'(sat(m_drops, 3))) begin failures++; $display("FAIL sat_step%0d got=%0d exp=%0d", j, o2_drop, sat(m_drops, 3)); end
    end
    checks++; if (o2_drop !== 2'd3 || drop_cnt !== 8'd8) begin failures++; $display("FAIL sat_final w2=%0d w8=%0d exp 3/8", o2_drop, drop_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(8'h01, 1'b0);
    tick(8'hF0, 1'b0);
    tick(8'h01, 1'b0);
    checks++; if (out_valid !== 1'b1 || pend !== 8'hF1 || drop_cnt !== 8'd0) begin failures++; $display("FAIL rmid_setup valid=%b pend=%h drop=%0d exp 1/f1/0", out_valid, pend, drop_cnt); end
    tick(8'h01, 1'b0);
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL rmid_drop got=%0d exp=1", drop_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || pend !== 8'h00 || drop_cnt !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_async valid=%b pend=%h drop=%0d busy=%b exp all 0", out_valid, pend, drop_cnt, busy); end
    @(negedge clk);
    {h, g, f, e, d, c, b, a} = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || pend !== 8'h00) begin failures++; $display("FAIL rmid_held valid=%b pend=%h exp 0/00", out_valid, pend); end
    @(negedge clk);
    {h, g, f, e, d, c, b, a} = 8'h00;
    rst_n = 1'b1;
    model_clear();
    for (int j = 0; j < 3; j++) begin
      tick(8'h00, 1'b1);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_quiet%0d valid=%b busy=%b exp 0/0", j, out_valid, busy); end
    end
    tick(8'h08, 1'b1);
    tick(8'h00, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_lane !== 3'd3) begin failures++; $display("FAIL rmid_resume valid=%b lane=%0d exp 1/3", out_valid, out_lane); end
  endtask

  task automatic test_random();
    logic [7:0] ev;
    logic rdy;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      ev = 8'($urandom) & 8'($urandom);
      rdy = $urandom_range(0, 3) != 0;
      tick(ev, rdy);
      checks++; if (pend !== exp_pend()) begin failures++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", n, pend, exp_pend()); end
      checks++; if (out_valid !== m_ov) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, out_valid, m_ov); end
      checks++; if (out_lane !== 3'(m_lane)) begin failures++; $display("FAIL rnd_lane cyc=%0d got=%0d exp=%0d", n, out_lane, m_lane); end
      checks++; if (drop_cnt !== 8'(sat(m_drops, 255))) begin failures++; $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", n, drop_cnt, sat(m_drops, 255)); end
      checks++; if (o2_drop !== 2'(sat(m_drops, 3))) begin failures++; $display("FAIL rnd_drop2 cyc=%0d got=%0d exp=%0d", n, o2_drop, sat(m_drops, 3)); end
      checks++; if (busy !== (m_ov || exp_pend() != 8'h00)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b", n, busy); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_all_lanes();
    test_fairness();
    test_stall_drop();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
